// File: rtl/key_cnt_pkg.sv
// Shared definitions for the key-driven BCD counter: FSM encodings and digit limit.
package key_cnt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_digit.sv
// One registered BCD digit with enable, up/down, carry/borrow chaining and clear.
// Digit updates on the edge after en_i; co_o is combinational from the current digit.
module bcd_digit
  import key_cnt_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic       up_i,
  output logic [3:0] dig_o,
  output logic       co_o
);

  logic [3:0] dig_q, dig_d;

  always_comb begin
    dig_d = dig_q;
    if (clr_i) begin
      dig_d = 4'd0;
    end else if (en_i) begin
      if (up_i) begin
        dig_d = (dig_q >= BCD_MAX) ? 4'd0 : dig_q + 4'd1;
      end else begin
        dig_d = (dig_q == 4'd0) ? BCD_MAX : dig_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dig_q <= 4'd0;
    end else begin
      dig_q <= dig_d;
    end
  end

  assign co_o  = en_i & (up_i ? (dig_q == BCD_MAX) : (dig_q == 4'd0));
  assign dig_o = dig_q;

endmodule

// File: rtl/key_bcd_counter.sv
// Start/pause/clear/direction key control of a DIGITS-wide BCD counter ticking at TICK_HZ.
// Keys act two edges after they rise; outputs are registered; no backpressure.
module key_bcd_counter
  import key_cnt_pkg::*;
#(
  parameter int CLK_HZ  = 12_000_000,
  parameter int TICK_HZ = 10,
  parameter int DIGITS  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  key_start,
  input  logic                  key_clr,
  input  logic                  key_dir,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  running,
  output logic                  dir_down,
  output logic                  wrap
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  // bit 0 = start, 1 = clr, 2 = dir
  logic [2:0] key_s_q, key_d_q, evt;
  state_e     state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic       dir_q, dir_d;
  logic       wrap_q, wrap_d;
  logic       tick;
  logic [DIGITS:0] carry;

  assign evt  = key_s_q & ~key_d_q;
  assign tick = (state_q == ST_RUN) && (pre_q == PRE_LAST);

  always_comb begin
    state_d = state_q;
    if (evt[1]) begin
      state_d = ST_IDLE;
    end else if (evt[0]) begin
      case (state_q)
        ST_IDLE:  state_d = ST_RUN;
        ST_RUN:   state_d = ST_PAUSE;
        ST_PAUSE: state_d = ST_RUN;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Prescaler only advances while staying in RUN, so every RUN entry restarts it.
  always_comb begin
    pre_d = '0;
    if (state_q == ST_RUN && state_d == ST_RUN) begin
      pre_d = tick ? '0 : pre_q + PW'(1);
    end
  end

  assign dir_d  = dir_q ^ evt[2];
  assign wrap_d = carry[DIGITS] & ~evt[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_s_q <= 3'b000;
      key_d_q <= 3'b000;
      state_q <= ST_IDLE;
      pre_q   <= '0;
      dir_q   <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      key_s_q <= {key_dir, key_clr, key_start};
      key_d_q <= key_s_q;
      state_q <= state_d;
      pre_q   <= pre_d;
      dir_q   <= dir_d;
      wrap_q  <= wrap_d;
    end
  end

  // Tick uses the current (pre-toggle) direction.
  assign carry[0] = tick;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .clk   (clk),
      .rst   (rst),
      .clr_i (evt[1]),
      .en_i  (carry[i]),
      .up_i  (~dir_q),
      .dig_o (bcd[4*i +: 4]),
      .co_o  (carry[i+1])
    );
  end

  assign running  = (state_q == ST_RUN);
  assign dir_down = dir_q;
  assign wrap     = wrap_q;

endmodule

// File: tb/tb_key_bcd_counter.sv
// Randomised and directed bench for key_bcd_counter against an integer-count reference model.
module tb_key_bcd_counter;

  localparam int CLK_HZ  = 100;
  localparam int TICK_HZ = 10;
  localparam int DIGITS  = 2;
  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam int MAXC    = 99;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic key_start = 1'b0;
  logic key_clr = 1'b0;
  logic key_dir = 1'b0;
  logic [4*DIGITS-1:0] bcd;
  logic running, dir_down, wrap;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: plain integer count, state 0=idle 1=run 2=pause
  int   m_cnt, m_state, m_pc;
  bit   m_dir, m_wrap;
  logic [2:0] m_k1, m_k2;

  key_bcd_counter #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_start (key_start),
    .key_clr   (key_clr),
    .key_dir   (key_dir),
    .bcd       (bcd),
    .running   (running),
    .dir_down  (dir_down),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
    logic [4*DIGITS-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_state = 0; m_pc = 0; m_dir = 0; m_wrap = 0;
    m_k1 = 3'b000; m_k2 = 3'b000;
  endtask

  task automatic model_edge();
    logic [2:0] ev;
    bit tk;
    ev   = m_k1 & ~m_k2;
    m_k2 = m_k1;
    m_k1 = {key_dir, key_clr, key_start};
    tk   = (m_state == 1) && (m_pc == DIV - 1);
    m_wrap = 0;
    if (m_state == 1) m_pc = (m_pc + 1) % DIV;
    if (tk) begin
      if (!m_dir) begin
        if (m_cnt == MAXC) begin m_cnt = 0; m_wrap = 1; end
        else m_cnt++;
      end else begin
        if (m_cnt == 0) begin m_cnt = MAXC; m_wrap = 1; end
        else m_cnt--;
      end
    end
    if (ev[1]) begin
      m_state = 0; m_cnt = 0; m_wrap = 0; m_pc = 0;
    end else if (ev[0]) begin
      m_state = (m_state == 1) ? 2 : 1;
      m_pc = 0;
    end
    if (ev[2]) m_dir = !m_dir;
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) model_reset();
    else model_edge();
    #1;
    check("bcd", 32'(bcd), 32'(to_bcd(m_cnt)));
    check("running", 32'(running), 32'(m_state == 1));
    check("dir_down", 32'(dir_down), 32'(m_dir));
    check("wrap", 32'(wrap), 32'(m_wrap));
  endtask

  task automatic pulse(input int which);
    if (which == 0) key_start = 1'b1;
    if (which == 1) key_clr = 1'b1;
    if (which == 2) key_dir = 1'b1;
    step();
    key_start = 1'b0; key_clr = 1'b0; key_dir = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit wrap_seen;
    int entries;
    logic prev_run;

    model_reset();
    repeat (3) step();
    rst = 1'b1;
    check("rst_bcd", 32'(bcd), 0);
    check("rst_running", 32'(running), 0);
    check("rst_dir", 32'(dir_down), 0);
    check("rst_wrap", 32'(wrap), 0);

    // 1: one start pulse, 95 cycles -> 9 ticks
    pulse(0);
    wrap_seen = 0;
    repeat (94) begin step(); if (wrap) wrap_seen = 1; end
    check("t1_bcd", 32'(bcd), 32'h09);
    check("t1_running", 32'(running), 1);
    check("t1_nowrap", 32'(wrap_seen), 0);

    // 2: up roll-over
    for (int i = 0; i < 2000 && m_cnt != MAXC; i++) step();
    check("t2_at99", 32'(bcd), 32'h99);
    for (int i = 0; i < 20; i++) begin step(); if (wrap) break; end
    check("t2_bcd", 32'(bcd), 32'h00);
    check("t2_wrap", 32'(wrap), 1);
    step();
    check("t2_wrap_1cyc", 32'(wrap), 0);

    // 3: down from zero
    pulse(1); step(); step();
    pulse(2); pulse(0);
    for (int i = 0; i < 30; i++) begin step(); if (wrap) break; end
    check("t3_bcd99", 32'(bcd), 32'h99);
    check("t3_wrap", 32'(wrap), 1);
    check("t3_dir", 32'(dir_down), 1);
    repeat (10) step();
    check("t3_bcd98", 32'(bcd), 32'h98);
    pulse(2); step(); step();

    // 4: pause / resume at 5
    pulse(1); step(); step();
    pulse(0);
    for (int i = 0; i < 200 && m_cnt != 5; i++) step();
    pulse(0);
    repeat (50) step();
    check("t4_hold", 32'(bcd), 32'h05);
    check("t4_paused", 32'(running), 0);
    pulse(0);
    repeat (10) step();
    check("t4_not_yet", 32'(bcd), 32'h05);
    step();
    check("t4_resume", 32'(bcd), 32'h06);

    // 5: clr + start land on the same edge as a tick at 37
    for (int i = 0; i < 1000 && !(m_cnt == 37 && m_state == 1 && m_pc == DIV - 2); i++) step();
    check("t5_at37", 32'(bcd), 32'h37);
    key_clr = 1'b1; key_start = 1'b1;
    step();
    key_clr = 1'b0; key_start = 1'b0;
    step();
    check("t5_bcd", 32'(bcd), 32'h00);
    check("t5_idle", 32'(running), 0);
    check("t5_wrap", 32'(wrap), 0);
    key_start = 1'b1;
    entries = 0;
    prev_run = running;
    repeat (20) begin
      step();
      if (running && !prev_run) entries++;
      prev_run = running;
    end
    key_start = 1'b0;
    check("t5_entries", 32'(entries), 1);

    // 6: async reset mid-count at 42 (counting down so dir_down is set)
    pulse(2);
    for (int i = 0; i < 1500 && m_cnt != 42; i++) step();
    check("t6_at42", 32'(bcd), 32'h42);
    #2;
    rst = 1'b0;
    #1;
    check("t6_bcd", 32'(bcd), 0);
    check("t6_running", 32'(running), 0);
    check("t6_dir", 32'(dir_down), 0);
    model_reset();
    repeat (3) step();
    rst = 1'b1;
    repeat (2) step();
    check("t6_idle", 32'(running), 0);

    // Random key traffic
    for (int c = 0; c < 4000; c++) begin
      key_start = ($urandom_range(0, 99) < 6);
      key_clr   = ($urandom_range(0, 299) < 2);
      key_dir   = ($urandom_range(0, 99) < 3);
      step();
    end
    key_start = 1'b0; key_clr = 1'b0; key_dir = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
